// File: rtl/ram_cache_pingpong.sv
// Two-bank ping-pong sample cache: the USB3 read path fills one bank while the
// DA side plays the other at a divided sample rate, with loop/one-shot playback.
module ram_cache_pingpong #(
  parameter int                  SAMPLE_W  = 8,
  parameter int                  CH        = 4,
  parameter int                  AW        = 8,
  parameter int                  RD_DIV    = 5,
  parameter logic [SAMPLE_W-1:0] IDLE_CODE = 8'h80,
  localparam int                 DW        = CH * SAMPLE_W
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_last,
  output logic          wr_ready,
  output logic          overflow,
  input  logic          rd_enable,
  input  logic          mode_loop,
  output logic [DW-1:0] q,
  output logic          q_valid,
  output logic          underrun,
  output logic [15:0]   underrun_cnt,
  output logic [1:0]    bank_full
);

  typedef enum logic [0:0] {W_FILL = 1'b0, W_WAIT = 1'b1} w_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_PLAY = 1'b1} r_state_t;

  localparam int             DIV_W     = 16;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RD_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]  ZERO_ADDR = {AW{1'b0}};
  localparam logic [AW-1:0]  ONE_ADDR  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]  LAST_ADDR = {AW{1'b1}};
  localparam logic [AW:0]    LEN_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]    LEN_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [DW-1:0]  IDLE_WORD = {CH{IDLE_CODE}};
  localparam logic [15:0]    CNT_MAX   = 16'hFFFF;
  localparam logic [15:0]    CNT_ONE   = 16'h0001;

  // Bank select is the MSB of the RAM address.
  logic [DW-1:0]    mem_r [0:(2**(AW+1))-1];

  w_state_t         w_state_r, w_state_s;
  logic             wb_r, wb_s;
  logic [AW-1:0]    wptr_r;
  logic [AW:0]      len_r [0:1];
  logic [1:0]       bank_full_r, bank_full_s;
  logic [1:0]       set_s, clr_s;
  logic             overflow_r;
  logic             write_s, commit_s;

  r_state_t         r_state_r, r_state_s;
  logic             rb_r, rb_s;
  logic [AW-1:0]    rptr_r, rptr_s;
  logic [AW-1:0]    rd_addr_s;
  logic [DIV_W-1:0] div_cnt_r;
  logic             tick_s, play_s, underrun_s, release_s, last_s;
  logic [DW-1:0]    q_r;
  logic             q_valid_r, underrun_r;
  logic [15:0]      underrun_cnt_r;

  assign tick_s       = rd_enable & (div_cnt_r == DIV_LAST);
  assign wr_ready     = (w_state_r == W_FILL);
  assign overflow     = overflow_r;
  assign q            = q_r;
  assign q_valid      = q_valid_r;
  assign underrun     = underrun_r;
  assign underrun_cnt = underrun_cnt_r;
  assign bank_full    = bank_full_r;

  // Writer: accept words while filling and decide when a frame is committed.
  always_comb begin
    write_s  = 1'b0;
    commit_s = 1'b0;
    if (w_state_r == W_FILL) begin
      write_s  = wr_en;
      commit_s = wr_en & (wr_last | (wptr_r == LAST_ADDR));
    end else begin
      write_s  = 1'b0;
      commit_s = 1'b0;
    end
  end

  // Reader: one RAM read per tick, end-of-bank handling for loop and one-shot.
  always_comb begin
    r_state_s  = r_state_r;
    rb_s       = rb_r;
    rptr_s     = rptr_r;
    play_s     = 1'b0;
    underrun_s = 1'b0;
    release_s  = 1'b0;
    rd_addr_s  = (r_state_r == R_PLAY) ? rptr_r : ZERO_ADDR;
    last_s     = ({1'b0, rd_addr_s} == (len_r[rb_r] - LEN_ONE));
    if (tick_s) begin
      if ((r_state_r == R_PLAY) || bank_full_r[rb_r]) begin
        play_s = 1'b1;
        if (last_s) begin
          if (mode_loop && !bank_full_r[~rb_r]) begin
            r_state_s = R_PLAY;
            rptr_s    = ZERO_ADDR;
          end else begin
            // Loop with a waiting bank switches gaplessly; one-shot goes idle.
            release_s = 1'b1;
            rb_s      = ~rb_r;
            rptr_s    = ZERO_ADDR;
            r_state_s = mode_loop ? R_PLAY : R_IDLE;
          end
        end else begin
          r_state_s = R_PLAY;
          rptr_s    = rd_addr_s + ONE_ADDR;
        end
      end else begin
        underrun_s = 1'b1;
      end
    end else begin
      play_s = 1'b0;
    end
  end

  // Bank ownership: commit and release always target different banks.
  always_comb begin
    set_s       = {commit_s & wb_r, commit_s & ~wb_r};
    clr_s       = {release_s & rb_r, release_s & ~rb_r};
    bank_full_s = (bank_full_r | set_s) & ~clr_s;
    wb_s        = commit_s ? ~wb_r : wb_r;
    w_state_s   = bank_full_s[wb_s] ? W_WAIT : W_FILL;
  end

  // Sample RAM write port; contents survive reset, validity lives in bank_full.
  always_ff @(posedge clock) begin
    if (write_s) begin
      mem_r[{wb_r, wptr_r}] <= wr_data;
    end
  end

  // Writer state, pointers, frame lengths and overflow flag.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      w_state_r   <= W_FILL;
      wb_r        <= 1'b0;
      wptr_r      <= ZERO_ADDR;
      len_r[0]    <= LEN_ZERO;
      len_r[1]    <= LEN_ZERO;
      bank_full_r <= 2'b00;
      overflow_r  <= 1'b0;
    end else begin
      w_state_r   <= w_state_s;
      wb_r        <= wb_s;
      bank_full_r <= bank_full_s;
      overflow_r  <= wr_en & (w_state_r == W_WAIT);
      if (commit_s) begin
        len_r[wb_r] <= {1'b0, wptr_r} + LEN_ONE;
        wptr_r      <= ZERO_ADDR;
      end else if (write_s) begin
        wptr_r <= wptr_r + ONE_ADDR;
      end
    end
  end

  // Sample-rate divider, reader state and registered DA outputs.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      div_cnt_r      <= DIV_ZERO;
      r_state_r      <= R_IDLE;
      rb_r           <= 1'b0;
      rptr_r         <= ZERO_ADDR;
      q_r            <= IDLE_WORD;
      q_valid_r      <= 1'b0;
      underrun_r     <= 1'b0;
      underrun_cnt_r <= 16'h0000;
    end else begin
      if (!rd_enable || tick_s) begin
        div_cnt_r <= DIV_ZERO;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_ONE;
      end
      r_state_r  <= r_state_s;
      rb_r       <= rb_s;
      rptr_r     <= rptr_s;
      q_valid_r  <= tick_s;
      underrun_r <= underrun_s;
      if (play_s) begin
        q_r <= mem_r[{rb_r, rd_addr_s}];
      end else if (underrun_s) begin
        q_r <= IDLE_WORD;
      end
      if (underrun_s && (underrun_cnt_r != CNT_MAX)) begin
        underrun_cnt_r <= underrun_cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_ram_cache_pingpong.sv
// Randomised-data bench for ram_cache_pingpong: expected playback streams are
// built from the written frames and the loop/one-shot rules.
module tb_ram_cache_pingpong;

  localparam logic [31:0] IDLE_W = 32'h80808080;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = 32'h0;
  logic        wr_last = 1'b0;
  logic        rd_enable = 1'b0;
  logic        mode_loop = 1'b0;
  logic        wr_ready, overflow, q_valid, underrun;
  logic [31:0] q;
  logic [15:0] underrun_cnt;
  logic [1:0]  bank_full;

  ram_cache_pingpong dut (
    .clock(clock), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .wr_last(wr_last), .wr_ready(wr_ready), .overflow(overflow),
    .rd_enable(rd_enable), .mode_loop(mode_loop), .q(q), .q_valid(q_valid),
    .underrun(underrun), .underrun_cnt(underrun_cnt), .bank_full(bank_full)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          und_seen = 0;
  logic [31:0] got_q[$];
  int          cyc_q[$];
  logic        rdy_q[$];
  logic [31:0] data[$];
  logic [31:0] exp_q[$];

  always @(posedge clock) cyc++;

  // Record every output sample with its cycle and the writer's ready state.
  always @(negedge clock) begin
    if (q_valid) begin
      got_q.push_back(q);
      cyc_q.push_back(cyc);
      rdy_q.push_back(wr_ready);
    end
    if (underrun) und_seen++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    cyc_q.delete();
    rdy_q.delete();
    und_seen = 0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_last = 1'b0;
    step(1);
    rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic write_word(input logic [31:0] d, input logic last);
    wr_en   = 1'b1;
    wr_data = d;
    wr_last = last;
    step(1);
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic wait_pulses(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check({"wait_", tag}, 64'(got_q.size() >= n), 64'd1);
  endtask

  task automatic compare_stream(input string tag);
    int lim;
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      check($sformatf("%s[%0d]", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
  endtask

  initial begin
    logic rdy_all;
    logic [31:0] x;
    int   k;

    // Starvation: idle words every RD_DIV cycles, counted as underruns.
    rd_enable = 1'b1;
    do_reset();
    check("rst_bank_full", 64'(bank_full), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_q", 64'(q), 64'(IDLE_W));
    step(15);
    check("idle_ucnt15", 64'(underrun_cnt), 64'd3);
    step(1);
    check("idle_pulses", 64'(got_q.size()), 64'd3);
    for (int i = 0; i < got_q.size(); i++) begin
      check("idle_q", 64'(got_q[i]), 64'(IDLE_W));
    end
    for (int i = 1; i < cyc_q.size(); i++) begin
      check("idle_spacing", 64'(cyc_q[i] - cyc_q[i-1]), 64'd5);
    end
    check("idle_und_seen", 64'(und_seen), 64'd3);

    // Full 256-word bank without wr_last, then one-shot playback.
    rd_enable = 1'b0;
    mode_loop = 1'b0;
    do_reset();
    data.delete();
    rdy_all = 1'b1;
    for (int i = 0; i < 256; i++) begin
      data.push_back($urandom);
      rdy_all &= wr_ready;
      write_word(data[i], 1'b0);
    end
    check("fill_ready", 64'(rdy_all & wr_ready), 64'd1);
    check("fill_bank_full", 64'(bank_full), 64'd1);
    check("fill_no_qv", 64'(got_q.size()), 64'd0);
    rd_enable = 1'b1;
    wait_pulses("oneshot", 260, 260 * 5 + 20);
    exp_q.delete();
    foreach (data[i]) exp_q.push_back(data[i]);
    repeat (4) exp_q.push_back(IDLE_W);
    compare_stream("oneshot");
    check("oneshot_und", 64'(und_seen), 64'd4);
    check("oneshot_bank_full", 64'(bank_full), 64'd0);

    // Loop a 4-word frame, pause mid-frame while committing a 2-word frame.
    rd_enable = 1'b0;
    do_reset();
    data.delete();
    for (int i = 0; i < 4; i++) begin
      data.push_back($urandom);
      write_word(data[i], i == 3);
    end
    check("loop_bank_full0", 64'(bank_full), 64'd1);
    mode_loop = 1'b1;
    rd_enable = 1'b1;
    wait_pulses("loop_a", 10, 10 * 5 + 20);
    rd_enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      data.push_back($urandom);
      write_word(data[4 + i], i == 1);
    end
    step(18);
    check("pause_quiet", 64'(got_q.size()), 64'd10);
    check("loop_bank_full1", 64'(bank_full), 64'd3);
    rd_enable = 1'b1;
    wait_pulses("loop_b", 22, 12 * 5 + 20);
    exp_q.delete();
    k = 0;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(data[k % 4]);
      k++;
    end
    while (k % 4 != 0) begin
      exp_q.push_back(data[k % 4]);
      k++;
    end
    for (int j = 0; exp_q.size() < 22; j++) exp_q.push_back(data[4 + (j % 2)]);
    compare_stream("loop");
    for (int i = 11; i < cyc_q.size(); i++) begin
      check("loop_gapless", 64'(cyc_q[i] - cyc_q[i-1]), 64'd5);
    end
    check("loop_bank0_rel", 64'(bank_full), 64'd2);
    check("loop_ucnt", 64'(underrun_cnt), 64'd0);

    // Both banks full: writer stalls, extra word overflows and is dropped.
    rd_enable = 1'b0;
    mode_loop = 1'b0;
    do_reset();
    data.delete();
    for (int i = 0; i < 512; i++) begin
      data.push_back($urandom);
      write_word(data[i], 1'b0);
    end
    check("both_wr_ready", 64'(wr_ready), 64'd0);
    check("both_bank_full", 64'(bank_full), 64'd3);
    check("ovf_before", 64'(overflow), 64'd0);
    write_word(32'hDEADBEEF, 1'b0);
    check("ovf_pulse", 64'(overflow), 64'd1);
    step(1);
    check("ovf_clear", 64'(overflow), 64'd0);
    rd_enable = 1'b1;
    wait_pulses("both", 512, 512 * 5 + 40);
    exp_q.delete();
    foreach (data[i]) exp_q.push_back(data[i]);
    compare_stream("both");
    if (rdy_q.size() >= 256) begin
      check("ready_before_release", 64'(rdy_q[254]), 64'd0);
      check("ready_on_release", 64'(rdy_q[255]), 64'd1);
    end else begin
      check("ready_samples", 64'(rdy_q.size()), 64'd256);
    end
    check("both_ucnt", 64'(underrun_cnt), 64'd0);
    check("both_bank_full_end", 64'(bank_full), 64'd0);

    // Single-word frame in one-shot mode.
    rd_enable = 1'b0;
    do_reset();
    x = $urandom;
    write_word(x, 1'b1);
    check("len1_bank_full", 64'(bank_full), 64'd1);
    rd_enable = 1'b1;
    wait_pulses("len1", 3, 3 * 5 + 20);
    exp_q.delete();
    exp_q.push_back(x);
    exp_q.push_back(IDLE_W);
    exp_q.push_back(IDLE_W);
    compare_stream("len1");
    check("len1_und", 64'(und_seen), 64'd2);

    // Reset while playing one bank and part-way through writing the other.
    rd_enable = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) write_word($urandom, i == 7);
    mode_loop = 1'b1;
    rd_enable = 1'b1;
    wait_pulses("mid", 3, 3 * 5 + 20);
    for (int i = 0; i < 3; i++) write_word($urandom, 1'b0);
    wr_en   = 1'b1;
    wr_data = $urandom;
    rst_n   = 1'b0;
    step(1);
    rst_n = 1'b1;
    wr_en = 1'b0;
    check("mrst_bank_full", 64'(bank_full), 64'd0);
    check("mrst_q", 64'(q), 64'(IDLE_W));
    check("mrst_q_valid", 64'(q_valid), 64'd0);
    check("mrst_underrun", 64'(underrun), 64'd0);
    check("mrst_overflow", 64'(overflow), 64'd0);
    check("mrst_ucnt", 64'(underrun_cnt), 64'd0);
    check("mrst_wr_ready", 64'(wr_ready), 64'd1);
    clear_mon();
    wait_pulses("mrst", 1, 5 + 20);
    exp_q.delete();
    exp_q.push_back(IDLE_W);
    compare_stream("mrst");
    check("mrst_ucnt_after", 64'(underrun_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_cache_pingpong.md
Name: ram_cache_pingpong

Overview:
- Parametrised successor to the single-bank USB3-to-DA RAM cache.
- Two banks in ping-pong: the USB3 slave-FIFO read path writes multi-channel sample words into one bank while the DA side plays the other at a divided sample rate.
- Adds frame-length commit (early `wr_last`), loop/one-shot playback, an idle code on starvation, and overflow/underrun reporting.
- Sits between the USB3 read state machine and the DA output registers.

Parameters:
- SAMPLE_W, 8, bits per channel sample.
- CH, 4, channels packed per word; word width DW = CH*SAMPLE_W (channel 0 in LSBs).
- AW, 8, bank address width; bank depth = 2^AW words.
- RD_DIV, 5, clock cycles per output sample (legal 2..65535).
- IDLE_CODE, 8'h80, per-channel value driven when no data is playing (DA mid-scale).

Ports:
- clock  in  1  single system clock; all logic is on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- wr_en  in  1  write strobe from USB3 read path; one word per cycle.
- wr_data  in  DW  sample word.
- wr_last  in  1  qualifies wr_en; this word ends the frame.
- wr_ready  out  1  write bank is free; words offered while low are dropped.
- overflow  out  1  one-cycle pulse: wr_en while wr_ready=0.
- rd_enable  in  1  playback run/pause.
- mode_loop  in  1  1 = replay the current bank until a new one is committed; 0 = one-shot.
- q  out  DW  DA sample word.
- q_valid  out  1  one-cycle pulse when q updates.
- underrun  out  1  one-cycle pulse when a sample tick finds no bank to play.
- underrun_cnt  out  16  saturating count of underrun pulses.
- bank_full  out  2  committed flag per bank.

Behaviour:
- Reset (rst_n=0 at an edge):
  - bank_full=0, write bank wb=0, read bank rb=0, pointers and tick counter 0.
  - q={CH{IDLE_CODE}}; q_valid, underrun, overflow=0; underrun_cnt=0; wr_ready=1 from the first cycle after reset.
  - Reset mid-frame discards partial and committed data.
- Storage: 2×2^AW×DW synchronous RAM, registered read, 1-cycle latency.
- Writer FSM W_FILL / W_WAIT:
  - W_FILL: wr_ready=1. Each wr_en writes wr_data to bank wb at wptr, then wptr++.
  - Commit when the write has wr_last=1 or wptr=2^AW-1: bank_full[wb]<=1, len[wb]<=wptr+1 (AW+1 bits), wb toggles, wptr<=0.
  - After commit: stay in W_FILL if the new wb is not full, else go to W_WAIT.
  - W_WAIT: wr_ready=0; return to W_FILL the cycle after the reader releases that bank.
  - wr_last with wr_en=0 is ignored.
- Sample tick: a counter runs 0..RD_DIV-1 while rd_enable=1; tick is asserted when the counter = RD_DIV-1. With rd_enable=0 the counter holds 0, the reader keeps its position, and there is no q_valid.
- Reader FSM R_IDLE / R_PLAY:
  - Every tick produces exactly one q_valid pulse, one cycle after the tick (after the RAM read). q holds its value between pulses.
  - R_IDLE, tick, bank_full[rb]=1: read rb at address 0, enter R_PLAY.
  - R_IDLE, tick, bank_full[rb]=0: q<=IDLE words, q_valid and underrun pulse, underrun_cnt++ (saturates at 16'hFFFF).
  - R_PLAY, tick: read rb at rptr. On rptr=len[rb]-1:
    - One-shot mode: release (bank_full[rb]<=0, rb toggles, go to R_IDLE); the next tick starts the other bank if it is full.
    - Loop mode, other bank full: release and switch to the other bank at address 0 (gapless).
    - Loop mode, other bank not full: rptr<=0 and replay rb.
  - mode_loop is sampled only at end of bank.
- Simultaneous events:
  - Writer commit and reader release in the same cycle touch different banks; both take effect.
  - wr_en at the exact cycle W_WAIT ends is accepted only if wr_ready was 1 in that cycle.
  - A frame of len=1 is legal.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, rd_enable=1, no writes, RD_DIV=5 -> q=32'h80808080; q_valid every 5 cycles; underrun_cnt=3 after 15 cycles.
- Write 256 words 0..255 (wr_last never asserted) -> bank_full=2'b01; wr_ready stays 1. One-shot playback -> q_valid values 0..255 in order, then underrun pulses and IDLE output.
- Write a 4-word frame A,B,C,D with wr_last on D, mode_loop=1 -> q cycles A,B,C,D,A,B… Then commit frame E,F -> after the next D, q=E,F,E,F; bank 0 released.
- Fill both banks (two 256-word frames) with rd_enable=0 -> wr_ready=0. Next wr_en -> overflow pulse, word dropped. Set rd_enable=1 -> wr_ready=1 one cycle after bank 0 finishes.
- Pulse rd_enable low for 20 cycles mid-frame -> no q_valid during the pause; sequence resumes at the next word, none skipped or repeated.
- Assert rst_n=0 one cycle mid-write and mid-play -> all outputs return to reset values the next cycle; bank_full=0.
